pads_cfg_master: RTL

- Wishbone initiator that programs the pad configuration slave's per-pad output-enable (OEN) registers at base 0x3000_6000.
- On a start pulse it compares a requested 44-bit OEN vector against a shadow of what the slave currently holds.
- It issues one single-beat Wishbone write per differing pad, or per pad when force_all is set.
- It sits beside the management SoC and lets firmware or bring-up logic reconfigure pad direction without hand-written bus loops.

---
 rtl/pads_cfg_pkg.sv | 22 ++
 rtl/pads_cfg_master.sv | 131 +++++++++++++
 2 files changed

// File: rtl/pads_cfg_pkg.sv
// Shared constants and types for the pad OEN configuration master.
// The reset pattern mirrors what the pad configuration slave holds out of reset.
package pads_cfg_pkg;

    localparam int NUM_PADS = 44;
    localparam int PAD_IDX_W = 6;
    localparam int TIMEOUT = 255;

    localparam logic [31:0] BASE_ADDR = 32'h3000_6000;
    localparam logic [31:0] ADR_STRIDE = 32'd4;

    localparam logic [NUM_PADS-1:0] PAD_OEN_RST = 44'hC70003FFFBD;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        GAP,
        FIN
    } state_t;

endpackage

// File: rtl/pads_cfg_master.sv
// Wishbone initiator that brings the slave's per-pad OEN registers in line
// with a requested vector, writing only the pads that differ unless forced.
module pads_cfg_master #(
    parameter int          NUM_PADS   = pads_cfg_pkg::NUM_PADS,
    parameter logic [31:0] BASE_ADDR  = pads_cfg_pkg::BASE_ADDR,
    parameter logic [31:0] ADR_STRIDE = pads_cfg_pkg::ADR_STRIDE,
    parameter int          TIMEOUT    = pads_cfg_pkg::TIMEOUT
) (
    input  logic                               clk,
    input  logic                               resetb,
    input  logic                               start,
    input  logic                               force_all,
    input  logic [NUM_PADS-1:0]                oen_target,
    output logic                               busy,
    output logic                               done,
    output logic                               err,
    output logic [pads_cfg_pkg::PAD_IDX_W-1:0] err_pad,
    output logic [NUM_PADS-1:0]                shadow_oen,
    output logic                               wbm_cyc_o,
    output logic                               wbm_stb_o,
    output logic                               wbm_we_o,
    output logic [3:0]                         wbm_sel_o,
    output logic [31:0]                        wbm_adr_o,
    output logic [31:0]                        wbm_dat_o,
    input  logic                               wbm_ack_i
);
    import pads_cfg_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PAD_IDX_W-1:0] IDX_LAST = PAD_IDX_W'(NUM_PADS - 1);

    state_t               state;
    state_t               state_d;
    logic [PAD_IDX_W-1:0] idx;
    logic [CNT_W-1:0]     cnt;
    logic [NUM_PADS-1:0]  target_q;
    logic                 force_q;

    logic diff;
    logic last;
    logic expired;
    logic in_req;

    assign diff    = force_q | (target_q[idx] != shadow_oen[idx]);
    assign last    = (idx == IDX_LAST);
    assign expired = (cnt == CNT_LAST);
    assign in_req  = (state == REQ);

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (start) state_d = SCAN;
            SCAN: begin
                if (diff) begin
                    state_d = REQ;
                end else if (last) begin
                    state_d = FIN;
                end
            end
            REQ: begin
                if (wbm_ack_i) begin
                    state_d = GAP;
                end else if (expired) begin
                    state_d = FIN;
                end
            end
            // The slave's registered ack lingers one cycle past stb.
            GAP:     state_d = last ? FIN : SCAN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            idx        <= '0;
            cnt        <= '0;
            target_q   <= '0;
            force_q    <= 1'b0;
            err        <= 1'b0;
            err_pad    <= '0;
            shadow_oen <= NUM_PADS'(PAD_OEN_RST);
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        target_q <= oen_target;
                        force_q  <= force_all;
                        idx      <= '0;
                        err      <= 1'b0;
                    end
                end
                SCAN: begin
                    cnt <= '0;
                    if (!diff && !last) idx <= idx + 1'b1;
                end
                REQ: begin
                    if (wbm_ack_i) begin
                        shadow_oen[idx] <= target_q[idx];
                    end else if (expired) begin
                        err     <= 1'b1;
                        err_pad <= idx;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: if (!last) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign wbm_cyc_o = in_req;
    assign wbm_stb_o = in_req;
    assign wbm_we_o  = in_req;
    assign wbm_sel_o = in_req ? 4'hF : 4'h0;
    assign wbm_adr_o = in_req ? BASE_ADDR + ADR_STRIDE * 32'(idx) : 32'h0;
    assign wbm_dat_o = in_req ? {31'b0, target_q[idx]} : 32'h0;

endmodule
